bch_dec_err_monitor: RTL and testbench

Downstream checker for the n-parallel SD-BCH decoder. Consumes the decoder's hard-decision output stream (out_codeword, out_out_start) together with the aligned golden comparison vector. Per codeword it counts bit errors, flags frame errors and keeps running totals for BER/FER reporting. Sits beside the clock-cycle confirm block on the decoder output in the SD-BCH bench and netlist runs.

---
 rtl/bch_dec_err_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_bch_dec_err_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_dec_err_monitor.sv
// ---------------------------------------------------------------------------
// bch_dec_err_monitor
//   Compares the SD-BCH decoder hard-decision output stream against the
//   aligned golden vector. For each codeword it counts bit errors and flags
//   frame errors. It also keeps saturating running totals for BER/FER reporting.
//
// Ports
//   clk                clock, all state on rising edge
//   in_Srst            synchronous active-high reset (overrides in_en)
//   in_en              clock enable, state holds while low
//   in_start           beat-0 marker of a decoded word
//   in_codeword        decoded bits for this beat
//   in_ref             golden bits for this beat
//   out_word_done      one-cycle pulse, a word has completed
//   out_word_err_bits  bit errors in the last completed word
//   out_frame_err      last completed word had at least one bit error
//   out_sync_err       one-cycle pulse, in_start arrived mid-word
//   out_tot_bit_err    saturating total bit errors
//   out_tot_frame_err  saturating total frame errors
//   out_tot_words      saturating total completed words
//   out_busy           high while a word is in progress
//
// Optional build macro ERR_POS_LOG_EN adds the following ports:
//   out_first_err_beat   first beat index with an error in the completed word
//   out_first_err_valid  the index is meaningful (equals out_frame_err)
// ---------------------------------------------------------------------------
module bch_dec_err_monitor #(
   parameter int unsigned PARALLELISM     = 4,
   parameter int unsigned CW_LEN          = 1020,
   parameter int unsigned BEAT_CNT_LEN    = 10,
   parameter int unsigned WORD_ERR_LEN    = 11,
   parameter int unsigned TOT_BIT_ERR_LEN = 32,
   parameter int unsigned TOT_WORD_LEN    = 16
) (
   input  logic                       clk,
   input  logic                       in_Srst,
   input  logic                       in_en,
   input  logic                       in_start,
   input  logic [PARALLELISM-1:0]     in_codeword,
   input  logic [PARALLELISM-1:0]     in_ref,
   output logic                       out_word_done,
   output logic [WORD_ERR_LEN-1:0]    out_word_err_bits,
   output logic                       out_frame_err,
   output logic                       out_sync_err,
   output logic [TOT_BIT_ERR_LEN-1:0] out_tot_bit_err,
   output logic [TOT_WORD_LEN-1:0]    out_tot_frame_err,
   output logic [TOT_WORD_LEN-1:0]    out_tot_words,
`ifdef ERR_POS_LOG_EN
   output logic [BEAT_CNT_LEN-1:0]    out_first_err_beat,
   output logic                       out_first_err_valid,
`endif
   output logic                       out_busy
);

   localparam int unsigned NUM_BEATS = CW_LEN / PARALLELISM;
   localparam int unsigned BE_W      = $clog2(PARALLELISM + 1);
   localparam logic [BEAT_CNT_LEN-1:0] LAST_BEAT = BEAT_CNT_LEN'(NUM_BEATS - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e                     state_q, state_d;
   logic [WORD_ERR_LEN-1:0]    acc_q, acc_d;
   logic [BEAT_CNT_LEN-1:0]    cnt_q, cnt_d;
   logic                       done_q, done_d;
   logic                       sync_q, sync_d;
   logic [WORD_ERR_LEN-1:0]    werr_q, werr_d;
   logic                       ferr_q, ferr_d;
   logic [TOT_BIT_ERR_LEN-1:0] tbit_q, tbit_d;
   logic [TOT_WORD_LEN-1:0]    tframe_q, tframe_d;
   logic [TOT_WORD_LEN-1:0]    twords_q, twords_d;

   logic [PARALLELISM-1:0]     diff;
   logic [BE_W-1:0]            beat_err;
   logic [WORD_ERR_LEN-1:0]    beat_err_ext;
   logic [WORD_ERR_LEN-1:0]    final_acc;
   logic                       complete;
   logic [TOT_BIT_ERR_LEN:0]   tbit_sum;

`ifdef ERR_POS_LOG_EN
   logic                       fseen_q, fseen_d;
   logic [BEAT_CNT_LEN-1:0]    fidx_q, fidx_d;
   logic [BEAT_CNT_LEN-1:0]    final_idx;
   logic [BEAT_CNT_LEN-1:0]    febeat_q, febeat_d;
   logic                       fevalid_q, fevalid_d;
`endif

   // Popcount of the mismatching bits in this beat.
   always_comb begin
      diff     = in_codeword ^ in_ref;
      beat_err = '0;
      for (int unsigned i = 0; i < PARALLELISM; i++) begin
         beat_err = beat_err + BE_W'(diff[i]);
      end
      beat_err_ext = WORD_ERR_LEN'(beat_err);
   end

   // Next-state logic: word sequencing plus completion bookkeeping.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sync_d    = 1'b0;
      complete  = 1'b0;
      final_acc = acc_q + beat_err_ext;
`ifdef ERR_POS_LOG_EN
      fseen_d   = fseen_q;
      fidx_d    = fidx_q;
      final_idx = fseen_q ? fidx_q : cnt_q;
`endif
      if (in_en) begin
         unique case (state_q)
            IDLE: begin
               if (in_start) begin
                  if (NUM_BEATS == 1) begin
                     complete  = 1'b1;
                     final_acc = beat_err_ext;
`ifdef ERR_POS_LOG_EN
                     final_idx = '0;
`endif
                  end else begin
                     state_d = RUN;
                     acc_d   = beat_err_ext;
                     cnt_d   = BEAT_CNT_LEN'(1);
`ifdef ERR_POS_LOG_EN
                     fseen_d = (beat_err != '0);
                     fidx_d  = '0;
`endif
                  end
               end
            end
            RUN: begin
               if (in_start) begin
                  // Drop the partial word and restart with this beat as beat 0.
                  sync_d = 1'b1;
                  acc_d  = beat_err_ext;
                  cnt_d  = BEAT_CNT_LEN'(1);
`ifdef ERR_POS_LOG_EN
                  fseen_d = (beat_err != '0);
                  fidx_d  = '0;
`endif
               end else if (cnt_q == LAST_BEAT) begin
                  complete = 1'b1;
                  state_d  = IDLE;
                  acc_d    = '0;
                  cnt_d    = '0;
`ifdef ERR_POS_LOG_EN
                  fseen_d  = 1'b0;
                  fidx_d   = '0;
`endif
               end else begin
                  acc_d = final_acc;
                  cnt_d = cnt_q + BEAT_CNT_LEN'(1);
`ifdef ERR_POS_LOG_EN
                  if (!fseen_q && beat_err != '0) begin
                     fseen_d = 1'b1;
                     fidx_d  = cnt_q;
                  end
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end

      done_d   = complete;
      werr_d   = complete ? final_acc : werr_q;
      ferr_d   = complete ? (final_acc != '0) : ferr_q;
      tbit_sum = {1'b0, tbit_q} + (TOT_BIT_ERR_LEN + 1)'(final_acc);
      tbit_d   = tbit_q;
      tframe_d = tframe_q;
      twords_d = twords_q;
      if (complete) begin
         tbit_d = tbit_sum[TOT_BIT_ERR_LEN] ? '1 : tbit_sum[TOT_BIT_ERR_LEN-1:0];
         if (twords_q != '1) twords_d = twords_q + TOT_WORD_LEN'(1);
         if (final_acc != '0 && tframe_q != '1) tframe_d = tframe_q + TOT_WORD_LEN'(1);
      end
`ifdef ERR_POS_LOG_EN
      febeat_d  = febeat_q;
      fevalid_d = fevalid_q;
      if (complete) begin
         fevalid_d = (final_acc != '0);
         febeat_d  = (final_acc != '0) ? final_idx : '0;
      end
`endif
   end

   // Pulse flops take done_d/sync_d every edge; both are 0 when in_en is low.
   always_ff @(posedge clk) begin
      if (in_Srst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         sync_q   <= 1'b0;
         werr_q   <= '0;
         ferr_q   <= 1'b0;
         tbit_q   <= '0;
         tframe_q <= '0;
         twords_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         sync_q   <= sync_d;
         werr_q   <= werr_d;
         ferr_q   <= ferr_d;
         tbit_q   <= tbit_d;
         tframe_q <= tframe_d;
         twords_q <= twords_d;
      end
   end

`ifdef ERR_POS_LOG_EN
   always_ff @(posedge clk) begin
      if (in_Srst) begin
         fseen_q   <= 1'b0;
         fidx_q    <= '0;
         febeat_q  <= '0;
         fevalid_q <= 1'b0;
      end else begin
         fseen_q   <= fseen_d;
         fidx_q    <= fidx_d;
         febeat_q  <= febeat_d;
         fevalid_q <= fevalid_d;
      end
   end

   assign out_first_err_beat  = febeat_q;
   assign out_first_err_valid = fevalid_q;
`endif

   assign out_word_done     = done_q;
   assign out_word_err_bits = werr_q;
   assign out_frame_err     = ferr_q;
   assign out_sync_err      = sync_q;
   assign out_tot_bit_err   = tbit_q;
   assign out_tot_frame_err = tframe_q;
   assign out_tot_words     = twords_q;
   assign out_busy          = (state_q == RUN);

endmodule

// File: tb/tb_bch_dec_err_monitor.sv
// Scoreboard bench for bch_dec_err_monitor: a main instance at default sizes
// and a small instance (one beat per word, 2-bit word counters) for saturation.
module tb_bch_dec_err_monitor;

   localparam int unsigned NB = 255;

   typedef struct {
      int unsigned cyc;
      int unsigned err;
      int unsigned frame;
      int unsigned tbit;
      int unsigned tframe;
      int unsigned twords;
      int unsigned fbeat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  cw = '0;
   logic [3:0]  rf = '0;
   logic        s_start = 1'b0;
   logic [3:0]  s_cw = '0;
   logic [3:0]  s_rf = '0;

   logic        done, frame, sync, busy;
   logic [10:0] werr;
   logic [31:0] tbit;
   logic [15:0] tframe, twords;
   logic        s_done, s_frame, s_sync, s_busy;
   logic [2:0]  s_werr;
   logic [31:0] s_tbit;
   logic [1:0]  s_tframe, s_twords;
`ifdef ERR_POS_LOG_EN
   logic [9:0]  fbeat;
   logic        fvalid;
   logic [0:0]  s_fbeat;
   logic        s_fvalid;
`endif

   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned m_bit = 0, m_frame = 0, m_words = 0;
   exp_t        q[$];
   exp_t        sq[$];
   int unsigned syncq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bch_dec_err_monitor #(
      .PARALLELISM(4), .CW_LEN(1020), .BEAT_CNT_LEN(10),
      .WORD_ERR_LEN(11), .TOT_BIT_ERR_LEN(32), .TOT_WORD_LEN(16)
   ) u_dut (
      .clk(clk), .in_Srst(rst), .in_en(en), .in_start(start),
      .in_codeword(cw), .in_ref(rf),
      .out_word_done(done), .out_word_err_bits(werr), .out_frame_err(frame),
      .out_sync_err(sync), .out_tot_bit_err(tbit), .out_tot_frame_err(tframe),
      .out_tot_words(twords),
`ifdef ERR_POS_LOG_EN
      .out_first_err_beat(fbeat), .out_first_err_valid(fvalid),
`endif
      .out_busy(busy)
   );

   bch_dec_err_monitor #(
      .PARALLELISM(4), .CW_LEN(4), .BEAT_CNT_LEN(1),
      .WORD_ERR_LEN(3), .TOT_BIT_ERR_LEN(32), .TOT_WORD_LEN(2)
   ) u_sat (
      .clk(clk), .in_Srst(rst), .in_en(en), .in_start(s_start),
      .in_codeword(s_cw), .in_ref(s_rf),
      .out_word_done(s_done), .out_word_err_bits(s_werr), .out_frame_err(s_frame),
      .out_sync_err(s_sync), .out_tot_bit_err(s_tbit), .out_tot_frame_err(s_tframe),
      .out_tot_words(s_twords),
`ifdef ERR_POS_LOG_EN
      .out_first_err_beat(s_fbeat), .out_first_err_valid(s_fvalid),
`endif
      .out_busy(s_busy)
   );

   function automatic void check(string name, int unsigned act, int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: pops expectations whenever a DUT presents a pulse.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (q.size() == 0) check("unexpected_done", 1, 0);
         else begin
            e = q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("err_bits", werr, e.err);
            check("frame_err", frame, e.frame);
            check("tot_bit_err", tbit, e.tbit);
            check("tot_frame_err", tframe, e.tframe);
            check("tot_words", twords, e.twords);
`ifdef ERR_POS_LOG_EN
            check("first_err_beat", fbeat, e.fbeat);
            check("first_err_valid", fvalid, e.frame);
`endif
         end
      end
      if (sync) begin
         if (syncq.size() == 0) check("unexpected_sync", 1, 0);
         else check("sync_cycle", cyc, syncq.pop_front());
      end
      if (s_done) begin
         if (sq.size() == 0) check("sat_unexpected_done", 1, 0);
         else begin
            e = sq.pop_front();
            check("sat_done_cycle", cyc, e.cyc);
            check("sat_err_bits", s_werr, e.err);
            check("sat_tot_bit_err", s_tbit, e.tbit);
            check("sat_tot_frame_err", s_tframe, e.tframe);
            check("sat_tot_words", s_twords, e.twords);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(string tag);
      check({tag, "_done"}, done, 0);
      check({tag, "_err_bits"}, werr, 0);
      check({tag, "_frame"}, frame, 0);
      check({tag, "_sync"}, sync, 0);
      check({tag, "_tot_bit"}, tbit, 0);
      check({tag, "_tot_frame"}, tframe, 0);
      check({tag, "_tot_words"}, twords, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // Sends nb beats of one word; error masks ma/mb at beats ea/eb.
   // xerr/xfirst are the hand-computed error count and first error beat.
   task automatic run_word(input int unsigned nb,
                           input int unsigned ea, input logic [3:0] ma,
                           input int unsigned eb, input logic [3:0] mb,
                           input int unsigned xerr, input int unsigned xfirst,
                           input int unsigned stall_at, input int unsigned stall_len,
                           input bit xsync);
      int unsigned s = 0;
      logic [3:0]  m;
      exp_t        e;
      for (int unsigned b = 0; b < nb; b++) begin
         if (stall_len != 0 && b == stall_at) begin
            en = 1'b0; start = 1'b1; cw = 4'hA; rf = 4'h5;
            repeat (stall_len) tick();
            en = 1'b1;
         end
         m     = (b == ea) ? ma : ((b == eb) ? mb : 4'h0);
         start = (b == 0);
         cw    = 4'($urandom);
         rf    = cw ^ m;
         tick();
         if (b == 0) begin
            s = cyc;
            if (xsync) syncq.push_back(s);
         end
      end
      start = 1'b0;
      if (nb == NB) begin
         m_words++;
         m_bit += xerr;
         if (xerr != 0) m_frame++;
         e.cyc    = s + NB - 1 + stall_len;
         e.err    = xerr;
         e.frame  = (xerr != 0);
         e.tbit   = m_bit;
         e.tframe = m_frame;
         e.twords = m_words;
         e.fbeat  = xfirst;
         q.push_back(e);
      end
   endtask

   localparam int unsigned NONE = 9999;

   initial begin
      exp_t e;
      repeat (3) tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      // Error-free word.
      run_word(NB, NONE, 4'h0, NONE, 4'h0, 0, 0, 0, 0, 1'b0);
      repeat (3) tick();
      // 0xF at beat 0 and 0x1 at beat 254: 5 errors.
      run_word(NB, 0, 4'hF, 254, 4'h1, 5, 0, 0, 0, 1'b0);
      repeat (2) tick();
      // Three back-to-back words: 0, 3, 0 errors.
      run_word(NB, NONE, 4'h0, NONE, 4'h0, 0, 0, 0, 0, 1'b0);
      run_word(NB, 7, 4'hB, NONE, 4'h0, 3, 7, 0, 0, 1'b0);
      run_word(NB, NONE, 4'h0, NONE, 4'h0, 0, 0, 0, 0, 1'b0);
      repeat (2) tick();
      // 100 beats carrying 7 errors, then a restart at beat 100 (2 errors).
      run_word(100, 10, 4'hF, 60, 4'h7, 0, 0, 0, 0, 1'b0);
      check("busy_mid_word", busy, 1);
      run_word(NB, 3, 4'h3, NONE, 4'h0, 2, 3, 0, 0, 1'b1);
      repeat (2) tick();
      // 20-cycle enable stall ahead of beat 50; one error at beat 50.
      run_word(NB, 50, 4'h1, NONE, 4'h0, 1, 50, 50, 20, 1'b0);
      repeat (2) tick();
      // Reset at beat 200 discards the word and clears everything.
      run_word(200, 20, 4'h1, NONE, 4'h0, 0, 0, 0, 0, 1'b0);
      check("busy_before_reset", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("midword_reset");
      m_bit = 0; m_frame = 0; m_words = 0;
      tick();
      // Recovery word after reset: 0x6 at beat 254 gives 2 errors.
      run_word(NB, 254, 4'h6, NONE, 4'h0, 2, 254, 0, 0, 1'b0);
      repeat (2) tick();

      // Saturation: five single-error words on the 2-bit counter instance.
      for (int unsigned k = 1; k <= 5; k++) begin
         s_start = 1'b1;
         s_cw    = 4'($urandom);
         s_rf    = s_cw ^ 4'h1;
         tick();
         e.cyc    = cyc;
         e.err    = 1;
         e.frame  = 1;
         e.tbit   = k;
         e.tframe = (k > 3) ? 3 : k;
         e.twords = (k > 3) ? 3 : k;
         e.fbeat  = 0;
         sq.push_back(e);
      end
      s_start = 1'b0;

      repeat (5) tick();
      check("pending_done", q.size(), 0);
      check("pending_sync", syncq.size(), 0);
      check("pending_sat_done", sq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
